// File: rtl/sample_strobe_gen.sv
// Qualifies the DCM LOCKED signal (synchronizer + settle delay), then divides the
// core clock into a programmable sample strobe that captures the probe inputs.
module sample_strobe_gen #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIV_WIDTH   = 24,
    parameter int LOCK_SETTLE = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  dcm_locked,
    input  logic                  wr_divider,
    input  logic [DIV_WIDTH-1:0]  divider,
    input  logic                  run,
    input  logic                  clr_status,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  core_ready,
    output logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  lock_lost
);

    localparam int SETTLE_W = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SETTLE    = 2'd1,
        S_READY     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic                   core_ready_q, core_ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [DIV_WIDTH-1:0]   div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [DATA_WIDTH-1:0]  sample_data_q, sample_data_d;
    logic                   locked_s;
    logic                   active;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign active   = core_ready_q & run;

    // Lock qualification: synchronizer, settle FSM and sticky loss flag
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], dcm_locked};
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        lock_lost_d  = lock_lost_q;
        if (clr_status) begin
            lock_lost_d = 1'b0;
        end
        case (state_q)
            S_WAIT_LOCK: begin
                settle_cnt_d = '0;
                if (locked_s) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_cnt_d = settle_cnt_q + 1'b1;
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                // Setting after the clear lets a same-cycle loss win over clr_status
                if (!locked_s) begin
                    state_d     = S_WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT_LOCK;
            end
        endcase
        core_ready_d = (state_q == S_READY);
    end

    // Sample divider: cnt counts down only, so any divider value is safe
    always_comb begin
        div_reg_d      = wr_divider ? divider : div_reg_q;
        sample_valid_d = 1'b0;
        sample_data_d  = sample_data_q;
        if (!active) begin
            cnt_d = div_reg_d;
        end else if (cnt_q == '0) begin
            sample_valid_d = 1'b1;
            sample_data_d  = data_in;
            cnt_d          = div_reg_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q         <= '0;
            state_q        <= S_WAIT_LOCK;
            settle_cnt_q   <= '0;
            core_ready_q   <= 1'b0;
            lock_lost_q    <= 1'b0;
            div_reg_q      <= '0;
            cnt_q          <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
        end else begin
            sync_q         <= sync_d;
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            core_ready_q   <= core_ready_d;
            lock_lost_q    <= lock_lost_d;
            div_reg_q      <= div_reg_d;
            cnt_q          <= cnt_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
        end
    end

    assign core_ready   = core_ready_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign lock_lost    = lock_lost_q;

endmodule

// File: tb/tb_sample_strobe_gen.sv
// Bench for sample_strobe_gen: directed lock/divider scenarios, a vector table,
// and randomized traffic checked every cycle against an edge-count reference model.
module tb_sample_strobe_gen;

    localparam int DW = 16;
    localparam int VW = 8;
    localparam int LS = 16;
    localparam int SS = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          dcm_locked;
    logic          wr_divider;
    logic [VW-1:0] divider;
    logic          run;
    logic          clr_status;
    logic [DW-1:0] data_in;
    logic          core_ready;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic          lock_lost;

    int vec_cnt = 0;
    int err_cnt = 0;

    sample_strobe_gen #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (VW),
        .LOCK_SETTLE(LS),
        .SYNC_STAGES(SS)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .dcm_locked  (dcm_locked),
        .wr_divider  (wr_divider),
        .divider     (divider),
        .run         (run),
        .clr_status  (clr_status),
        .data_in     (data_in),
        .core_ready  (core_ready),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .lock_lost   (lock_lost)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Reference model: lock readiness from the run length of consecutive
    // synchronized-high samples, strobes from edge distance since the last reload.
    bit            m_hist[$];
    int            m_run_len;
    bit            m_rdy;
    bit            m_core;
    bit            m_lost;
    bit            m_valid;
    logic [VW-1:0] m_div;
    logic [DW-1:0] m_data;
    longint        m_edge = 0;
    longint        m_reload;
    int            m_per;

    function automatic void model_edge();
        bit            ls;
        bit            old_rdy;
        bit            old_core;
        bit            act;
        logic [VW-1:0] old_div;
        m_edge++;
        if (!reset_n) begin
            m_hist.delete();
            for (int k = 0; k < SS; k++) m_hist.push_back(1'b0);
            m_run_len = 0;
            m_rdy     = 0;
            m_core    = 0;
            m_lost    = 0;
            m_valid   = 0;
            m_div     = '0;
            m_data    = '0;
            m_reload  = m_edge;
            m_per     = 0;
            return;
        end
        ls       = m_hist[0];
        old_rdy  = m_rdy;
        old_core = m_core;
        old_div  = m_div;
        act      = old_core && run;
        if (wr_divider) m_div = divider;
        if (!act) begin
            m_valid  = 0;
            m_reload = m_edge;
            m_per    = int'(m_div);
        end else if ((m_edge - m_reload) == longint'(m_per + 1)) begin
            m_valid  = 1;
            m_data   = data_in;
            m_reload = m_edge;
            m_per    = int'(old_div);
        end else begin
            m_valid = 0;
        end
        m_run_len = ls ? m_run_len + 1 : 0;
        m_rdy     = (m_run_len >= LS + 1);
        m_core    = old_rdy;
        if (old_rdy && !ls) m_lost = 1;
        else if (clr_status) m_lost = 0;
        m_hist.push_back(bit'(dcm_locked));
        void'(m_hist.pop_front());
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, m_edge);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("model_core_ready", 32'(core_ready), 32'(m_core));
        check("model_sample_valid", 32'(sample_valid), 32'(m_valid));
        check("model_sample_data", 32'(sample_data), 32'(m_data));
        check("model_lock_lost", 32'(lock_lost), 32'(m_lost));
        @(negedge clock);
    endtask

    typedef struct {
        logic          run;
        logic          wr;
        logic [VW-1:0] div;
        logic [DW-1:0] din;
        logic          exp_v;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic w, input int dv, input int di,
                                input logic v, input int d);
        vec_t e;
        e.run   = r;
        e.wr    = w;
        e.div   = VW'(dv);
        e.din   = DW'(di);
        e.exp_v = v;
        e.exp_d = DW'(d);
        tbl.push_back(e);
    endfunction

    initial begin
        int first_v;
        int second_v;
        int low_left;

        add(0, 1, 3, 'h00, 0, 'h00);
        add(1, 0, 0, 'h10, 0, 'h00);
        add(1, 0, 0, 'h11, 0, 'h00);
        add(1, 0, 0, 'h12, 0, 'h00);
        add(1, 0, 0, 'h13, 1, 'h13);
        add(1, 0, 0, 'h14, 0, 'h13);
        add(1, 0, 0, 'h15, 0, 'h13);
        add(1, 0, 0, 'h16, 0, 'h13);
        add(1, 0, 0, 'h17, 1, 'h17);
        add(1, 1, 1, 'h18, 0, 'h17);
        add(1, 0, 0, 'h19, 0, 'h17);
        add(1, 0, 0, 'h1A, 0, 'h17);
        add(1, 0, 0, 'h1B, 1, 'h1B);
        add(1, 0, 0, 'h1C, 0, 'h1B);
        add(1, 0, 0, 'h1D, 1, 'h1D);
        add(1, 0, 0, 'h1E, 0, 'h1D);
        add(1, 0, 0, 'h1F, 1, 'h1F);
        add(0, 0, 0, 'h20, 0, 'h1F);
        add(0, 1, 0, 'h21, 0, 'h1F);
        add(1, 0, 0, 'h22, 1, 'h22);
        add(1, 0, 0, 'h23, 1, 'h23);
        add(1, 0, 0, 'h24, 1, 'h24);
        add(0, 1, 2, 'h25, 0, 'h24);
        add(1, 0, 0, 'h26, 0, 'h24);
        add(1, 0, 0, 'h27, 0, 'h24);
        add(1, 0, 0, 'h28, 1, 'h28);
        add(1, 0, 0, 'h29, 0, 'h28);

        reset_n    = 1'b0;
        dcm_locked = 1'b0;
        wr_divider = 1'b0;
        divider    = '0;
        run        = 1'b0;
        clr_status = 1'b0;
        data_in    = '0;

        // Reset state
        repeat (3) step();
        check("rst_core_ready", 32'(core_ready), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_sample_data", 32'(sample_data), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);

        // Lock qualify: ready exactly SS+LS+1 edges after the sampling edge
        reset_n = 1'b1;
        repeat (4) step();
        dcm_locked = 1'b1;
        for (int i = 1; i <= SS + LS + 2; i++) begin
            step();
            if (i == SS + LS + 1) check("lock_ready_early", 32'(core_ready), 32'd0);
        end
        check("lock_ready_on_time", 32'(core_ready), 32'd1);

        // Glitchy lock restarts the settle period
        reset_n    = 1'b0;
        dcm_locked = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        dcm_locked = 1'b1;
        repeat (8) step();
        dcm_locked = 1'b0;
        step();
        dcm_locked = 1'b1;
        for (int i = 1; i <= SS + LS + 2; i++) begin
            step();
            if (i == SS + LS + 1) check("glitch_ready_early", 32'(core_ready), 32'd0);
        end
        check("glitch_ready_on_time", 32'(core_ready), 32'd1);
        check("glitch_lock_lost", 32'(lock_lost), 32'd0);

        // Divider vector table
        for (int i = 0; i < tbl.size(); i++) begin
            run        = tbl[i].run;
            wr_divider = tbl[i].wr;
            divider    = tbl[i].div;
            data_in    = tbl[i].din;
            step();
            check($sformatf("tbl_valid[%0d]", i), 32'(sample_valid), 32'(tbl[i].exp_v));
            check($sformatf("tbl_data[%0d]", i), 32'(sample_data), 32'(tbl[i].exp_d));
        end

        // Maximum divider value: period of 2^VW edges
        run        = 1'b0;
        wr_divider = 1'b1;
        divider    = '1;
        step();
        wr_divider = 1'b0;
        run        = 1'b1;
        first_v    = -1;
        second_v   = -1;
        for (int i = 1; i <= 600; i++) begin
            data_in = DW'(i);
            step();
            if (sample_valid === 1'b1) begin
                if (first_v < 0) first_v = i;
                else if (second_v < 0) second_v = i;
            end
        end
        check("maxdiv_first", 32'(first_v), 32'd256);
        check("maxdiv_second", 32'(second_v), 32'd512);

        // Lock loss mid-run
        run        = 1'b0;
        wr_divider = 1'b1;
        divider    = VW'(5);
        step();
        wr_divider = 1'b0;
        run        = 1'b1;
        repeat (7) step();
        dcm_locked = 1'b0;
        repeat (SS + 3) step();
        check("loss_core_ready", 32'(core_ready), 32'd0);
        check("loss_sample_valid", 32'(sample_valid), 32'd0);
        check("loss_lock_lost", 32'(lock_lost), 32'd1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("loss_cleared", 32'(lock_lost), 32'd0);
        dcm_locked = 1'b1;
        repeat (SS + LS + 2) step();
        check("relock_ready", 32'(core_ready), 32'd1);
        dcm_locked = 1'b0;
        step();
        step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("loss_set_wins", 32'(lock_lost), 32'd1);

        // Reset mid-run returns divider to 0
        dcm_locked = 1'b1;
        repeat (SS + LS + 2) step();
        wr_divider = 1'b1;
        divider    = VW'(3);
        step();
        wr_divider = 1'b0;
        repeat (2) step();
        reset_n = 1'b0;
        step();
        check("midrst_core_ready", 32'(core_ready), 32'd0);
        check("midrst_sample_valid", 32'(sample_valid), 32'd0);
        check("midrst_sample_data", 32'(sample_data), 32'd0);
        check("midrst_lock_lost", 32'(lock_lost), 32'd0);
        reset_n = 1'b1;
        repeat (SS + LS + 2) step();
        check("midrst_relock", 32'(core_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            data_in = DW'(16'hA0 + i);
            step();
            check($sformatf("midrst_n0_valid[%0d]", i), 32'(sample_valid), 32'd1);
            check($sformatf("midrst_n0_data[%0d]", i), 32'(sample_data), 32'(16'hA0 + i));
        end

        // Randomized traffic against the reference model
        low_left = 0;
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 599) != 0);
            if (low_left > 0) begin
                dcm_locked = 1'b0;
                low_left--;
            end else begin
                dcm_locked = 1'b1;
                if ($urandom_range(0, 99) == 0) low_left = int'($urandom_range(1, 4));
            end
            wr_divider = ($urandom_range(0, 15) == 0);
            divider    = ($urandom_range(0, 7) == 0) ? VW'($urandom_range(0, 255))
                                                     : VW'($urandom_range(0, 4));
            run        = ($urandom_range(0, 19) != 0);
            clr_status = ($urandom_range(0, 15) == 0);
            data_in    = DW'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
